// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the pending-write entry type
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: newest-value lookup of one read index across pending writes
// Ports: q/rd_ptr/count describe the queue, out_* the output register, idx the
// queried register; hit/data return the youngest matching value (0 when none).
module wb_bypass_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  wb_entry_t [DEPTH-1:0] q,
  input  logic [PW-1:0]         rd_ptr,
  input  logic [CW-1:0]         count,
  input  logic                  out_vld,
  input  logic [ADDR_W-1:0]     out_addr,
  input  logic [DATA_W-1:0]     out_data,
  input  logic [ADDR_W-1:0]     idx,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);
  logic [PW-1:0] p;
  // Output register is oldest; queue scanned head to tail so the youngest match lands last.
  always_comb begin
    hit = out_vld && out_addr == idx;
    data = hit ? out_data : '0;
    p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = rd_ptr + PW'(i);
      if (CW'(i) < count && q[p].addr == idx) begin
        hit = 1'b1;
        data = q[p].data;
      end
    end
    if (idx == ZERO_REG) begin
      hit = 1'b0;
      data = '0;
    end
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: queues results, drains one register-file write per cycle, forwards pending values
// Ports: wb_* result handshake (dest = wb_reg_out ? wb_rd : wb_rt), drain_en/flush control,
// reg_* registered write port, rs/rt read indices with byp1/byp2 forwarding, count occupancy.
module reg_writeback_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rt,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_reg_out,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              drain_en,
  input  logic              flush,
  output logic              reg_wre,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              byp1_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp2_data,
  output logic [CW-1:0]     count
);
  wb_entry_t [DEPTH-1:0] q;
  logic [PW-1:0] wp, rp;
  logic [ADDR_W-1:0] w_addr;
  logic store, pop;
  assign wb_ready = count != CW'(DEPTH);
  assign w_addr = wb_reg_out ? wb_rd : wb_rt;
  // r0 writes complete the handshake but are never stored.
  assign store = wb_valid && wb_ready && !flush && w_addr != ZERO_REG;
  assign pop = drain_en && count != '0 && !flush;
  always_ff @(posedge clk)
    if (store) q[wp] <= '{addr: w_addr, data: wb_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      reg_wre <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      reg_wre <= 1'b0;
    end else begin
      if (store) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        reg_waddr <= q[rp].addr;
        reg_wdata <= q[rp].data;
      end
      count <= count + CW'(store) - CW'(pop);
      reg_wre <= pop;
    end
  end
  wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .q(q), .rd_ptr(rp), .count(count), .out_vld(reg_wre), .out_addr(reg_waddr),
    .out_data(reg_wdata), .idx(rs), .hit(byp1_hit), .data(byp1_data)
  );
  wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .q(q), .rd_ptr(rp), .count(count), .out_vld(reg_wre), .out_addr(reg_waddr),
    .out_data(reg_wdata), .idx(rt), .hit(byp2_hit), .data(byp2_data)
  );
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed and random checks of reg_writeback_unit
module tb_reg_writeback_unit;
  import cpu_pkg::*;
  logic clk = 0, rst_n = 0, wb_valid = 0, wb_reg_out = 0, drain_en = 0, flush = 0;
  logic [4:0] wb_rt = 0, wb_rd = 0, rs = 0, rt = 0;
  logic [31:0] wb_data = 0;
  logic wb_ready, reg_wre, byp1_hit, byp2_hit;
  logic [4:0] reg_waddr;
  logic [31:0] reg_wdata, byp1_data, byp2_data;
  logic [2:0] count;
  int total = 0, bad = 0;
  wb_entry_t mq[$];
  wb_entry_t ex;
  logic ex_wre, mready, m_hit;
  logic [31:0] m_data;
  logic [31:0] mrf[32], drf[32];

  reg_writeback_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rt(wb_rt),
    .wb_rd(wb_rd), .wb_reg_out(wb_reg_out), .wb_data(wb_data), .drain_en(drain_en),
    .flush(flush), .reg_wre(reg_wre), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .rs(rs), .rt(rt), .byp1_hit(byp1_hit), .byp1_data(byp1_data), .byp2_hit(byp2_hit),
    .byp2_data(byp2_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_reg_out = 0; wb_rt = a; wb_data = d;
    tick();
    wb_valid = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_wre", reg_wre, 0);
    chk("rst_waddr", reg_waddr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst_n = 1;
    tick();
    // destination select
    drain_en = 1;
    wb_valid = 1; wb_rt = 3; wb_rd = 7; wb_reg_out = 1; wb_data = 32'hAA;
    tick();
    wb_valid = 0;
    chk("ds_count1", count, 1);
    chk("ds_wre_lat", reg_wre, 0);
    tick();
    chk("ds_wre_rd", reg_wre, 1);
    chk("ds_waddr_rd", reg_waddr, 7);
    chk("ds_wdata_rd", reg_wdata, 32'hAA);
    tick();
    chk("ds_wre_pulse", reg_wre, 0);
    chk("ds_waddr_hold", reg_waddr, 7);
    wb_valid = 1; wb_reg_out = 0; wb_data = 32'hBB;
    tick();
    wb_valid = 0;
    tick();
    chk("ds_waddr_rt", reg_waddr, 3);
    chk("ds_wdata_rt", reg_wdata, 32'hBB);
    tick();
    wb_valid = 1; wb_rd = 0; wb_reg_out = 1; wb_data = 32'hCC;
    chk("r0_ready", wb_ready, 1);
    tick();
    wb_valid = 0;
    chk("r0_count", count, 0);
    tick();
    chk("r0_nowre", reg_wre, 0);
    // full and back-pressure
    drain_en = 0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i);
    chk("full_count", count, 4);
    chk("full_ready", wb_ready, 0);
    drain_en = 1; wb_valid = 1; wb_rt = 9; wb_reg_out = 0; wb_data = 32'h109;
    #1 chk("full_ready_drain", wb_ready, 0);
    tick();
    chk("pop1_addr", reg_waddr, 1);
    chk("pop1_count", count, 3);
    chk("pop1_ready", wb_ready, 1);
    tick();
    wb_valid = 0;
    chk("pop2_addr", reg_waddr, 2);
    chk("pushpop_count", count, 3);
    tick();
    chk("pop3_addr", reg_waddr, 3);
    chk("pop3_data", reg_wdata, 32'h103);
    tick();
    chk("pop4_addr", reg_waddr, 4);
    chk("pop4_wre", reg_wre, 1);
    tick();
    chk("pop5_addr", reg_waddr, 9);
    chk("pop5_data", reg_wdata, 32'h109);
    chk("pop5_count", count, 0);
    tick();
    chk("drain_idle", reg_wre, 0);
    // bypass priority
    drain_en = 0;
    push(5, 32'h11);
    push(5, 32'h22);
    rs = 5; rt = 0;
    #1;
    chk("byp_hit", byp1_hit, 1);
    chk("byp_newest", byp1_data, 32'h22);
    chk("byp_r0_hit", byp2_hit, 0);
    chk("byp_r0_data", byp2_data, 0);
    rt = 5;
    drain_en = 1;
    tick();
    chk("byp_mix_data", byp1_data, 32'h22);
    chk("byp2_mix_data", byp2_data, 32'h22);
    tick();
    chk("byp_outreg_hit", byp1_hit, 1);
    chk("byp_outreg_data", byp1_data, 32'h22);
    tick();
    chk("byp_commit_hit", byp1_hit, 0);
    chk("byp_commit_data", byp1_data, 0);
    // flush
    drain_en = 0;
    push(10, 32'hA0); push(11, 32'hB0); push(12, 32'hC0);
    drain_en = 1;
    tick();
    chk("fl_pre_wre", reg_wre, 1);
    chk("fl_pre_count", count, 2);
    flush = 1; wb_valid = 1; wb_rt = 13; wb_reg_out = 0; wb_data = 32'hD0;
    rs = 11; rt = 13;
    tick();
    flush = 0; wb_valid = 0;
    chk("fl_count", count, 0);
    chk("fl_wre", reg_wre, 0);
    chk("fl_byp1", byp1_hit, 0);
    chk("fl_byp2", byp2_hit, 0);
    tick();
    chk("fl_after_wre", reg_wre, 0);
    tick();
    chk("fl_after_wre2", reg_wre, 0);
    // reset mid-burst
    drain_en = 0;
    push(6, 32'h66); push(7, 32'h77);
    drain_en = 1;
    tick();
    rs = 7; rt = 6;
    #1 chk("mid_pre_wre", reg_wre, 1);
    rst_n = 0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_wre", reg_wre, 0);
    chk("mid_ready", wb_ready, 1);
    chk("mid_byp1", byp1_hit, 0);
    chk("mid_byp2", byp2_hit, 0);
    tick();
    rst_n = 1;
    tick();
    chk("mid_post_wre", reg_wre, 0);
    tick();
    chk("mid_post_wre2", reg_wre, 0);
    // random stream against a behavioural queue and register-file model
    for (int r = 0; r < 32; r++) begin mrf[r] = 0; drf[r] = 0; end
    ex_wre = 0; ex = '0;
    for (int n = 0; n < 400; n++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_rt = 5'($urandom_range(0, 7));
      wb_rd = 5'($urandom_range(0, 7));
      wb_reg_out = 1'($urandom_range(0, 1));
      wb_data = $urandom;
      drain_en = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      mready = mq.size() != 4;
      #1 chk("rnd_ready", wb_ready, mready);
      ex_wre = 0;
      if (flush) mq.delete();
      else begin
        if (drain_en && mq.size() > 0) begin
          ex_wre = 1;
          ex = mq.pop_front();
          mrf[ex.addr] = ex.data;
        end
        if (wb_valid && mready && (wb_reg_out ? wb_rd : wb_rt) != 0)
          mq.push_back('{addr: wb_reg_out ? wb_rd : wb_rt, data: wb_data});
      end
      tick();
      chk("rnd_wre", reg_wre, ex_wre);
      chk("rnd_count", count, mq.size());
      if (ex_wre) begin
        chk("rnd_waddr", reg_waddr, ex.addr);
        chk("rnd_wdata", reg_wdata, ex.data);
      end
      if (reg_wre) drf[reg_waddr] = reg_wdata;
      rs = 5'($urandom_range(0, 7));
      m_hit = ex_wre && ex.addr == rs;
      m_data = m_hit ? ex.data : 0;
      foreach (mq[k]) if (mq[k].addr == rs) begin m_hit = 1; m_data = mq[k].data; end
      #1;
      chk("rnd_byp_hit", byp1_hit, m_hit);
      chk("rnd_byp_data", byp1_data, m_data);
    end
    for (int r = 0; r < 32; r++) chk("rnd_rf", drf[r], mrf[r]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
